// File: rtl/smoldvi_pkg.sv
// Shared constants for the smoldvi video timing block: common presets,
// sync polarities, counter width and the DVI control bundle.
package smoldvi_pkg;

   localparam int CTR_BITS = 12;

   // Sync polarities: the asserted level of hsync/vsync
   localparam logic SYNC_NEG = 1'b0;
   localparam logic SYNC_POS = 1'b1;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam logic VGA_HSYNC_POL = SYNC_NEG;
   localparam logic VGA_VSYNC_POL = SYNC_NEG;

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;
   localparam logic SVGA_HSYNC_POL = SYNC_POS;
   localparam logic SVGA_VSYNC_POL = SYNC_POS;

   // Control signals that travel together towards the DVI encoder
   typedef struct packed {
      logic den;
      logic hsync;
      logic vsync;
   } dvi_ctrl_t;

   // Converts a raw "sync asserted" flag into the pin level for a polarity
   function automatic logic sync_level(logic asserted, logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/smoldvi_delay_line.sv
// Fixed-depth register pipe with per-bit reset values; depth 0 is a wire.
// Reset clears every stage so nothing in flight survives a reset.
module smoldvi_delay_line #(
   parameter int                 WIDTH     = 1,
   parameter int                 DEPTH     = 1,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      // Each stage takes the value of the one before it
      always_comb begin
         stage_d[0] = d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end

      // Stage registers, flushed to the idle value on reset
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= RESET_VAL;
            end
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= stage_d[i];
            end
         end
      end

      assign q = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/smoldvi_timing.sv
// Free-running DVI raster timing generator. Requests pixels one cycle
// after the counter position and delays den/hsync/vsync by the pixel
// source latency so they line up with the returned pixel data.
module smoldvi_timing
   import smoldvi_pkg::*;
#(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   LATENCY   = 2
) (
   input  logic                clk_pix,
   input  logic                rst_n_pix,
   output logic                req,
   output logic [CTR_BITS-1:0] req_x,
   output logic [CTR_BITS-1:0] req_y,
   output logic                frame_start,
   output logic                line_start,
   output logic                den,
   output logic                hsync,
   output logic                vsync
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam logic [CTR_BITS-1:0] H_LAST = CTR_BITS'(H_TOTAL - 1);
   localparam logic [CTR_BITS-1:0] V_LAST = CTR_BITS'(V_TOTAL - 1);
   localparam dvi_ctrl_t CTRL_IDLE = '{den: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};

   logic [CTR_BITS-1:0] h_q, h_d;
   logic [CTR_BITS-1:0] v_q, v_d;
   logic                req_q, req_d;
   logic [CTR_BITS-1:0] req_x_q, req_x_d;
   logic [CTR_BITS-1:0] req_y_q, req_y_d;
   logic                frame_start_q, frame_start_d;
   logic                line_start_q, line_start_d;
   dvi_ctrl_t           ctrl_q, ctrl_d;
   dvi_ctrl_t           ctrl_dly;
   logic                active_raw, hsync_raw, vsync_raw;

   // Raw raster decode of the current counter position
   always_comb begin
      active_raw = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
      hsync_raw  = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
      vsync_raw  = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
   end

   // Counter advance and next values for the request-side and control registers
   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      req_d         = active_raw;
      req_x_d       = active_raw ? h_q : '0;
      req_y_d       = active_raw ? v_q : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
      ctrl_d.den    = active_raw;
      ctrl_d.hsync  = sync_level(hsync_raw, HSYNC_POL);
      ctrl_d.vsync  = sync_level(vsync_raw, VSYNC_POL);
   end

   // Raster counters and the first register stage for all outputs
   always_ff @(posedge clk_pix or negedge rst_n_pix) begin
      if (!rst_n_pix) begin
         h_q           <= '0;
         v_q           <= '0;
         req_q         <= 1'b0;
         req_x_q       <= '0;
         req_y_q       <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         ctrl_q        <= CTRL_IDLE;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         req_q         <= req_d;
         req_x_q       <= req_x_d;
         req_y_q       <= req_y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         ctrl_q        <= ctrl_d;
      end
   end

   smoldvi_delay_line #(
      .WIDTH     ($bits(dvi_ctrl_t)),
      .DEPTH     (LATENCY),
      .RESET_VAL (CTRL_IDLE)
   ) u_ctrl_dly (
      .clk   (clk_pix),
      .rst_n (rst_n_pix),
      .d     (ctrl_q),
      .q     (ctrl_dly)
   );

   assign req         = req_q;
   assign req_x       = req_x_q;
   assign req_y       = req_y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign den         = ctrl_dly.den;
   assign hsync       = ctrl_dly.hsync;
   assign vsync       = ctrl_dly.vsync;

endmodule

// File: doc/smoldvi_timing.md
SMOLDVI_TIMING -- requirements
Module: smoldvi_timing

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- HSYNC_POL, 0, asserted level of hsync.
- VSYNC_POL, 0, asserted level of vsync.
- LATENCY, 2, pixel-source latency in cycles (0..15).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_pix, in, 1, pixel clock; the only clock.
- rst_n_pix, in, 1, asynchronous active-low reset.
- req, out, 1, pixel request; the upstream source presents pixel (req_x, req_y) LATENCY cycles later.
- req_x, out, 12, requested column.
- req_y, out, 12, requested row.
- frame_start, out, 1, one-cycle pulse aligned with the request for (0,0).
- line_start, out, 1, one-cycle pulse aligned with h==0 on every line.
- den, out, 1, data enable, to the DVI encoder.
- hsync, out, 1, horizontal sync, to the DVI encoder.
- vsync, out, 1, vertical sync, to the DVI encoder.

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; each SHALL be at most 4096.
REQ-004 Counter h SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-005 Counter v SHALL increment only when h wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same cycle.
REQ-006 Raw active SHALL be (h<H_ACTIVE) and (v<V_ACTIVE).
REQ-007 Raw hsync SHALL be asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
REQ-008 Raw vsync SHALL be asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; the whole line is covered, so vsync edges coincide with h==0.
REQ-009 Cycle alignment: when the counters hold (h,v) at cycle t, the request-side outputs SHALL be registered and valid at cycle t+1.
- req = raw active.
- req_x = h when active, else 0.
- req_y = v when active, else 0.
- line_start = (h==0).
- frame_start = (h==0 and v==0).
REQ-010 den, hsync and vsync for counter position (h,v) SHALL appear at cycle t+1+LATENCY through a LATENCY-stage register delay; LATENCY=0 means they align with req.
REQ-011 hsync output SHALL equal HSYNC_POL when raw hsync is asserted and ~HSYNC_POL otherwise; vsync likewise with VSYNC_POL.
REQ-012 Over one frame, req SHALL be high for exactly H_ACTIVE*V_ACTIVE cycles, and den SHALL be high for exactly the same number of cycles.
REQ-013 The block has no stall or backpressure path; timing SHALL be free-running.

Reset
REQ-014 Assertion of rst_n_pix SHALL immediately and asynchronously force the following values.
- h=0, v=0.
- req=0, req_x=0, req_y=0.
- frame_start=0, line_start=0.
- den=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- All delay-stage registers to these idle values.
REQ-015 On the first clock edge after release, the counters SHALL be at (0,0), and at the end of that cycle req=1, req_x=0, req_y=0, frame_start=1 and line_start=1.
REQ-016 Reset asserted mid-frame SHALL discard all in-flight delay-line contents; no stale den or sync pulse SHALL be emitted after release.

Structure
REQ-017 Timing preset constants SHALL live in a shared package, smoldvi_pkg.
- 640x480@60 values.
- 800x600@60 values.
- Sync polarities.
- Counter width constant CTR_BITS=12.
REQ-018 One sub-module, smoldvi_delay_line, SHALL be used: a parameterised width x depth register pipe with per-bit reset values, where depth 0 is a wire.

Verification
Small config for REQ-019..REQ-022: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), LATENCY=2, both polarities 0.
REQ-019 Release reset -> cycle 1: req=1, (0,0), frame_start=1; cycle 3: den=1; cycles 1-4: req_x = 0,1,2,3; cycle 5: req=0.
REQ-020 Run 2 frames -> req high for 12 cycles per 48-cycle frame; den pattern identical to req shifted by 2.
REQ-021 Line 0 -> hsync low for h in {5,6}, seen at cycles t+3 (outputs at cycles 8-9); high elsewhere.
REQ-022 Line v=4 -> vsync low for exactly 8 consecutive cycles, starting 3 cycles after counters reach (0,4).
REQ-023 Assert reset while den=1 mid-line, then release -> den=0 and syncs idle until the new frame's first den at cycle 3.
REQ-024 Default 640x480, LATENCY=0 -> frame period 800*525 = 420000 cycles; frame_start pulses exactly once per period.
